// File: rtl/chamber_pump_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// chamber_pump_ctrl_pkg
// This package is shared by the chamber pump controller and the port
// controllers.
//   - Two-bit state encoding of the chamber pump FSM.
//   - Default evacuate and pressurize durations, in clock cycles.
//   - A helper that reports whether a state is a transfer state.
// -----------------------------------------------------------------------------
package chamber_pump_ctrl_pkg;

    localparam int EVAC_CYCLES_DEFAULT  = 8;
    localparam int PRESS_CYCLES_DEFAULT = 6;

    localparam logic [1:0] ST_PRESSURIZED  = 2'd0;
    localparam logic [1:0] ST_EVACUATING   = 2'd1;
    localparam logic [1:0] ST_EVACUATED    = 2'd2;
    localparam logic [1:0] ST_PRESSURIZING = 2'd3;

    function automatic logic is_transfer(input logic [1:0] state);
        return (state == ST_EVACUATING) || (state == ST_PRESSURIZING);
    endfunction

endpackage

// File: rtl/chamber_pump_ctrl_if.sv
// -----------------------------------------------------------------------------
// chamber_pump_ctrl_if
// This interface bundles the request, port-status and status signals of the
// chamber pump controller.
//   master : the side that drives the requests and port states (the system side)
//   slave  : the pump controller itself
// Signals:
//   EvacReq, PressReq    level requests to evacuate or pressurize the chamber
//   OuterOpen, InnerOpen port states, where 1 means open
//   EVState              1 only while the chamber is fully evacuated
//   Busy                 1 while a transfer is in progress
//   Fault                1 while a transfer is paused by an open port
//   Remaining [7:0]      cycles left in the current transfer
// -----------------------------------------------------------------------------
interface chamber_pump_ctrl_if;

    logic       EvacReq;
    logic       PressReq;
    logic       OuterOpen;
    logic       InnerOpen;
    logic       EVState;
    logic       Busy;
    logic       Fault;
    logic [7:0] Remaining;

    modport master (
        output EvacReq, PressReq, OuterOpen, InnerOpen,
        input  EVState, Busy, Fault, Remaining
    );

    modport slave (
        input  EvacReq, PressReq, OuterOpen, InnerOpen,
        output EVState, Busy, Fault, Remaining
    );

endinterface

// File: rtl/chamber_pump_ctrl_cycle_timer.sv
// -----------------------------------------------------------------------------
// cycle_timer
// This is an 8-bit loadable down-counter with a hold enable and a zero flag.
// Ports:
//   clk, rst_n      clock and asynchronous active-low reset
//   load_i          loads load_val_i; this takes priority over counting
//   load_val_i[7:0] the value to load
//   en_i            decrements by one when set; holds when clear
//   count_o[7:0]    the current count
//   zero_o          set when the count is 0
// The counter saturates at 0 and never wraps.
// -----------------------------------------------------------------------------
module cycle_timer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_i,
    input  logic [7:0] load_val_i,
    input  logic       en_i,
    output logic [7:0] count_o,
    output logic       zero_o
);

    logic [7:0] count_q;
    logic [7:0] count_d;

    always_comb begin
        // NOTE: every path assigns count_d first, so no latch can be inferred.
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (en_i && (count_q != 8'd0)) begin
            count_d = count_q - 8'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign zero_o  = (count_q == 8'd0);

endmodule

// File: rtl/chamber_pump_ctrl.sv
// -----------------------------------------------------------------------------
// chamber_pump_ctrl
// This is the evacuate/pressurize sequencer for an airlock chamber.
// Ports:
//   Clock  single clock; all state changes occur on its rising edge
//   Reset  asynchronous active-low reset
//   bus    chamber_pump_ctrl_if.slave, which carries the requests, the port
//          states and the registered status outputs
// Parameters:
//   EVAC_CYCLES  / PRESS_CYCLES  transfer lengths in cycles (legal 1..255)
// -----------------------------------------------------------------------------
module chamber_pump_ctrl
    import chamber_pump_ctrl_pkg::*;
#(
    parameter int EVAC_CYCLES  = EVAC_CYCLES_DEFAULT,
    parameter int PRESS_CYCLES = PRESS_CYCLES_DEFAULT
) (
    input  logic                Clock,
    input  logic                Reset,
    chamber_pump_ctrl_if.slave  bus
);

    localparam logic [7:0] EVAC_LOAD  = EVAC_CYCLES[7:0];
    localparam logic [7:0] PRESS_LOAD = PRESS_CYCLES[7:0];

    logic [1:0] state_q, state_d;
    logic       evstate_q, busy_q, fault_q, fault_d;
    logic       load, dec, timer_zero, port_open;
    logic [7:0] load_val, remaining;

    assign port_open = bus.OuterOpen | bus.InnerOpen;

    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        load_val = 8'd0;
        dec      = 1'b0;
        fault_d  = 1'b0;
        case (state_q)
            ST_PRESSURIZED: begin
                if (bus.EvacReq && !bus.PressReq && !port_open) begin
                    state_d  = ST_EVACUATING;
                    load     = 1'b1;
                    load_val = EVAC_LOAD;
                end
            end
            ST_EVACUATED: begin
                if (bus.PressReq && !bus.EvacReq && !port_open) begin
                    state_d  = ST_PRESSURIZING;
                    load     = 1'b1;
                    load_val = PRESS_LOAD;
                end
            end
            ST_EVACUATING, ST_PRESSURIZING: begin
                // An open port freezes the count and raises Fault. Requests
                // have no effect until the transfer finishes.
                fault_d = port_open;
                dec     = !port_open;
                // The 1 -> 0 edge also completes the transfer. A zero count
                // here can only come from an out-of-range parameter, so the
                // transfer finishes instead of stalling.
                if ((dec && remaining == 8'd1) || timer_zero) begin
                    state_d = (state_q == ST_EVACUATING) ? ST_EVACUATED
                                                         : ST_PRESSURIZED;
                end
            end
            default: state_d = ST_PRESSURIZED;
        endcase
    end

    // The status flags are decoded from the next state into their own flops.
    // EVState and Busy are therefore clean register outputs and never glitch
    // from a multi-bit state decode.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q   <= ST_PRESSURIZED;
            evstate_q <= 1'b0;
            busy_q    <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            evstate_q <= (state_d == ST_EVACUATED);
            busy_q    <= is_transfer(state_d);
            fault_q   <= fault_d;
        end
    end

    cycle_timer u_timer (
        .clk        (Clock),
        .rst_n      (Reset),
        .load_i     (load),
        .load_val_i (load_val),
        .en_i       (dec),
        .count_o    (remaining),
        .zero_o     (timer_zero)
    );

    assign bus.EVState   = evstate_q;
    assign bus.Busy      = busy_q;
    assign bus.Fault     = fault_q;
    assign bus.Remaining = remaining;

endmodule

// File: tb/tb_chamber_pump_ctrl.sv
// -----------------------------------------------------------------------------
// tb_chamber_pump_ctrl
// This is a directed, table-driven bench for chamber_pump_ctrl with
// EVAC_CYCLES=8 and PRESS_CYCLES=6. Each record holds the inputs applied
// before a rising edge and the outputs expected after that edge.
// -----------------------------------------------------------------------------
module tb_chamber_pump_ctrl;

    logic Clock = 1'b0;
    logic Reset;

    always #5 Clock = ~Clock;

    chamber_pump_ctrl_if bus ();

    chamber_pump_ctrl #(
        .EVAC_CYCLES  (8),
        .PRESS_CYCLES (6)
    ) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    typedef struct {
        logic       evac;
        logic       press;
        logic       outer;
        logic       inner;
        logic       ev;
        logic       busy;
        logic       fault;
        logic [7:0] rem;
        string      name;
    } vec_t;

    vec_t vecs[$];
    int   tests = 0;
    int   fails = 0;

    task automatic add(input logic e, input logic p, input logic o, input logic i,
                       input logic ev, input logic b, input logic f,
                       input logic [7:0] r, input string n);
        vec_t v;
        v.evac = e; v.press = p; v.outer = o; v.inner = i;
        v.ev = ev; v.busy = b; v.fault = f; v.rem = r; v.name = n;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string name, input logic ev, input logic b,
                             input logic f, input logic [7:0] r);
        check({name, ".EVState"},   {7'd0, bus.EVState}, {7'd0, ev});
        check({name, ".Busy"},      {7'd0, bus.Busy},    {7'd0, b});
        check({name, ".Fault"},     {7'd0, bus.Fault},   {7'd0, f});
        check({name, ".Remaining"}, bus.Remaining,       r);
    endtask

    task automatic drive(input logic e, input logic p, input logic o, input logic i);
        bus.EvacReq = e; bus.PressReq = p; bus.OuterOpen = o; bus.InnerOpen = i;
    endtask

    // Applies one record. The inputs change 1 ns after an edge, and the
    // outputs are sampled 1 ns after the following edge.
    task automatic step(input vec_t v);
        drive(v.evac, v.press, v.outer, v.inner);
        @(posedge Clock);
        #1;
        check_all(v.name, v.ev, v.busy, v.fault, v.rem);
    endtask

    initial begin
        // ---------------- vector table ----------------
        for (int k = 0; k < 5; k++) add(0,0,0,0, 0,0,0,8'd0, "idle_after_reset");
        add(0,1,0,0, 0,0,0,8'd0, "press_in_pressurized_ignored");
        add(1,0,0,1, 0,0,0,8'd0, "evac_inner_open_ignored");
        add(1,1,0,0, 0,0,0,8'd0, "evac_and_press_ignored");
        add(1,0,0,0, 0,1,0,8'd8, "evac_start");
        add(0,1,0,0, 0,1,0,8'd7, "evac_press_req_ignored");
        for (int r = 6; r >= 1; r--) add(0,0,0,0, 0,1,0,8'(r), "evac_count");
        add(0,0,0,0, 1,0,0,8'd0, "evacuated");
        add(1,0,0,0, 1,0,0,8'd0, "evac_in_evacuated_ignored");
        add(1,1,0,0, 1,0,0,8'd0, "both_in_evacuated_ignored");
        add(0,1,1,0, 1,0,0,8'd0, "press_outer_open_ignored");
        add(0,1,0,0, 0,1,0,8'd6, "press_start_evstate_falls");
        for (int r = 5; r >= 1; r--) add(0,0,0,0, 0,1,0,8'(r), "press_count");
        add(0,0,0,0, 0,0,0,8'd0, "pressurized");
        // Evacuation paused at Remaining=5: the outer port is open for 3 edges.
        add(1,0,0,0, 0,1,0,8'd8, "fevac_start");
        for (int r = 7; r >= 5; r--) add(0,0,0,0, 0,1,0,8'(r), "fevac_count");
        for (int k = 0; k < 3; k++) add(1,0,1,0, 0,1,1,8'd5, "fevac_paused");
        for (int r = 4; r >= 1; r--) add(0,0,0,0, 0,1,0,8'(r), "fevac_resume");
        add(0,0,0,0, 1,0,0,8'd0, "fevac_done");
        // Pressurization paused for one edge by the inner port.
        add(0,1,0,0, 0,1,0,8'd6, "fpress_start");
        add(0,0,0,1, 0,1,1,8'd6, "fpress_paused");
        for (int r = 5; r >= 1; r--) add(0,0,0,0, 0,1,0,8'(r), "fpress_resume");
        add(0,0,0,0, 0,0,0,8'd0, "fpress_done");

        // ---------------- reset ----------------
        drive(0,0,0,0);
        Reset = 1'b1;
        #1 Reset = 1'b0;
        #1 check_all("reset_async", 0, 0, 0, 8'd0);
        repeat (2) @(posedge Clock);
        #1 check_all("reset_held", 0, 0, 0, 8'd0);
        Reset = 1'b1;

        foreach (vecs[n]) step(vecs[n]);

        // ---------------- asynchronous reset mid-transfer ----------------
        drive(1,0,0,0);
        @(posedge Clock);
        #1 check_all("ar_start", 0, 1, 0, 8'd8);
        drive(0,0,0,0);
        repeat (5) @(posedge Clock);
        #1 check_all("ar_at3", 0, 1, 0, 8'd3);
        #2 Reset = 1'b0;            // mid-cycle, well away from any edge
        #1 check_all("ar_immediate", 0, 0, 0, 8'd0);
        @(posedge Clock);
        #1 check_all("ar_held", 0, 0, 0, 8'd0);
        Reset = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge Clock);
            #1 check_all("ar_no_evstate_pulse", 0, 0, 0, 8'd0);
        end
        // The first edge after the release honours a new request.
        Reset = 1'b0;
        #2 Reset = 1'b1;
        drive(1,0,0,0);
        @(posedge Clock);
        #1 check_all("first_edge_after_release", 0, 1, 0, 8'd8);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
